// File: rtl/nibble_bus_memory.sv
// Memory side of the 4-bit CPU nibble bus: program memory, a 16-nibble zero-page RAM and a host
// program loader that holds the CPU in reset until a full program has been streamed in.
module nibble_bus_memory #(
  parameter int unsigned PROG_WORDS = 64,
  parameter int unsigned DATA_WORDS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_addr,
  input  logic [3:0] bus_hi,
  input  logic [3:0] bus_wdata,
  output logic [3:0] bus_rdata,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [3:0] ld_data,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       cpu_rst_n
);

  localparam int unsigned NIB = PROG_WORDS * 3;
  localparam int unsigned IW  = $clog2(NIB);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]    r_state, w_state_d;
  logic [IW-1:0] r_wptr, w_wptr_d;
  logic          r_ld_done, r_cpu_rst_n;
  logic          w_accept, w_last, w_run, w_store, w_pc_ok;
  logic [9:0]    w_pc;
  logic [IW-1:0] w_fetch_idx;

  logic [3:0] r_prog [NIB];
  logic [3:0] r_data [DATA_WORDS];

  // Flat nibble pointer: word w, nibble n lives at w*3 + n.
  assign ld_ready  = (r_state == ST_LOAD);
  assign w_accept  = ld_ready && ld_valid && !ld_start;
  assign w_last    = w_accept && (r_wptr == IW'(NIB - 1));
  assign ld_done   = r_ld_done;
  assign cpu_rst_n = r_cpu_rst_n;

  always_comb begin
    w_state_d = r_state;
    w_wptr_d  = r_wptr;
    case (r_state)
      ST_IDLE: begin
        if (ld_start) begin
          w_state_d = ST_LOAD;
          w_wptr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (ld_start) begin
          w_wptr_d = '0;
        end else if (w_accept) begin
          w_wptr_d = w_last ? '0 : r_wptr + IW'(1);
          if (w_last) w_state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ld_start) begin
          w_state_d = ST_LOAD;
          w_wptr_d  = '0;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_ld_done   <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wptr      <= w_wptr_d;
      r_ld_done   <= w_last;
      r_cpu_rst_n <= (w_state_d == ST_RUN);
    end
  end

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_prog[r_wptr] <= ld_data;
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_store = w_run && (bus_hi == 4'b0011);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_WORDS; i++) r_data[i] <= 4'h0;
    end else if (w_store) begin
      r_data[bus_addr[3:0]] <= bus_wdata;
    end
  end

  assign w_pc        = {bus_addr, bus_hi[3:2]};
  assign w_pc_ok     = ({22'd0, w_pc} < PROG_WORDS);
  assign w_fetch_idx = IW'({2'b00, w_pc} * 12'd3 + {10'd0, bus_hi[1:0]});

  always_comb begin
    bus_rdata = 4'h0;
    if (w_run) begin
      if (bus_hi[1:0] != 2'b11) begin
        if (w_pc_ok) bus_rdata = r_prog[w_fetch_idx];
      end else if (bus_hi[3:2] == 2'b01) begin
        bus_rdata = r_data[bus_addr[3:0]];
      end
    end
  end

endmodule

// File: tb/tb_nibble_bus_memory.sv
// Scoreboard bench for nibble_bus_memory with PROG_WORDS=4: stimulus queues expectations per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_nibble_bus_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_addr;
  logic [3:0] bus_hi, bus_wdata, bus_rdata;
  logic       ld_start, ld_valid, ld_ready, ld_done, cpu_rst_n;
  logic [3:0] ld_data;

  nibble_bus_memory #(.PROG_WORDS(4), .DATA_WORDS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_hi    (bus_hi),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  localparam int SIG_RDATA = 0;
  localparam int SIG_CPURST = 1;
  localparam int SIG_READY = 2;
  localparam int SIG_DONE = 3;

  typedef struct {
    string      name;
    int         sig;
    logic [3:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_sig(input string name, input int sig, input logic [3:0] v);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = v;
    q.push_back(e);
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e = q.pop_front();
      case (e.sig)
        SIG_RDATA:  act = bus_rdata;
        SIG_CPURST: act = {3'b000, cpu_rst_n};
        SIG_READY:  act = {3'b000, ld_ready};
        default:    act = {3'b000, ld_done};
      endcase
      check(e.name, act, e.exp);
    end
  end

  always @(negedge clk) begin
    if (rst_n && ld_valid && ld_ready && !ld_start) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic [3:0] hi, input logic [3:0] wd);
    bus_addr  = a;
    bus_hi    = hi;
    bus_wdata = wd;
  endtask

  // Streams 12 nibbles base, base+1, ... with gaps; must be entered in a LOAD cycle.
  task automatic load_prog(input logic [3:0] base);
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 4'(i);
      tick();
      if (i % 3 == 1) begin
        ld_valid = 1'b0;
        tick();
      end
    end
    ld_valid = 1'b0;
    expect_sig("done_pulse", SIG_DONE, 4'h1);
    expect_sig("cpu_rst_run", SIG_CPURST, 4'h1);
    expect_sig("ready_run", SIG_READY, 4'h0);
    tick();
    expect_sig("done_low", SIG_DONE, 4'h0);
    expect_sig("cpu_rst_hold", SIG_CPURST, 4'h1);
    check("accept_count", 4'(acc_cnt), 4'd12);
  endtask

  task automatic fetch(input string name, input logic [9:0] pc, input logic [1:0] ph,
                       input logic [3:0] exp);
    bus(pc[9:2], {pc[1:0], ph}, 4'h0);
    expect_sig(name, SIG_RDATA, exp);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 4'h0;
    bus(8'h00, 4'b0111, 4'h0);
    tick();
    tick();
    expect_sig("rst_cpu", SIG_CPURST, 4'h0);
    expect_sig("rst_ready", SIG_READY, 4'h0);
    expect_sig("rst_done", SIG_DONE, 4'h0);
    for (int h = 0; h < 16; h++) begin
      bus(8'h05, 4'(h), 4'h0);
      expect_sig("rst_rdata", SIG_RDATA, 4'h0);
      tick();
    end
    rst_n = 1'b1;
    bus(8'h00, 4'b0111, 4'h0);
    tick();
    expect_sig("idle_ready", SIG_READY, 4'h0);

    // Initial load of 1..C.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    expect_sig("load_ready", SIG_READY, 4'h1);
    expect_sig("load_cpu_rst", SIG_CPURST, 4'h0);
    expect_sig("load_rdata", SIG_RDATA, 4'h0);
    load_prog(4'h1);

    for (int a = 0; a < 16; a++) begin
      bus(8'(a), 4'b0111, 4'h0);
      expect_sig("ram_cleared", SIG_RDATA, 4'h0);
      tick();
    end
    fetch("pc2_ph0", 10'd2, 2'd0, 4'h7);
    fetch("pc2_ph1", 10'd2, 2'd1, 4'h8);
    fetch("pc2_ph2", 10'd2, 2'd2, 4'h9);
    fetch("pc0_ph0", 10'd0, 2'd0, 4'h1);
    fetch("pc3_ph2", 10'd3, 2'd2, 4'hC);

    // Store then load.
    bus(8'h05, 4'b0011, 4'hA);
    expect_sig("store_rdata", SIG_RDATA, 4'h0);
    tick();
    bus(8'h05, 4'b0111, 4'h0);
    expect_sig("load_after_store", SIG_RDATA, 4'hA);
    tick();
    bus(8'h35, 4'b0111, 4'h0);
    expect_sig("load_upper_ignored", SIG_RDATA, 4'hA);
    tick();
    bus(8'h04, 4'b0111, 4'h0);
    expect_sig("load_neighbour", SIG_RDATA, 4'h0);
    tick();

    // Out-of-range PCs and reserved codes.
    for (int p = 0; p < 3; p++) fetch("pc4_zero", 10'd4, 2'(p), 4'h0);
    for (int p = 0; p < 3; p++) fetch("pc1023_zero", 10'd1023, 2'(p), 4'h0);
    bus(8'h05, 4'b1111, 4'h3);
    expect_sig("rsvd_1111", SIG_RDATA, 4'h0);
    tick();
    bus(8'h05, 4'b1011, 4'h3);
    expect_sig("rsvd_1011", SIG_RDATA, 4'h0);
    tick();
    bus(8'h05, 4'b0111, 4'h0);
    expect_sig("rsvd_no_write", SIG_RDATA, 4'hA);
    tick();

    // Restart from RUN, then restart mid-load with a dropped nibble.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    expect_sig("run_restart_cpu", SIG_CPURST, 4'h0);
    expect_sig("run_restart_ready", SIG_READY, 4'h1);
    expect_sig("run_restart_rdata", SIG_RDATA, 4'h0);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = 4'hD;
      tick();
    end
    ld_start = 1'b1;
    ld_data  = 4'hE;
    expect_sig("restart_cpu_low", SIG_CPURST, 4'h0);
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    expect_sig("restart_cpu_low2", SIG_CPURST, 4'h0);
    load_prog(4'h3);
    fetch("reload_pc0_ph0", 10'd0, 2'd0, 4'h3);
    fetch("reload_pc3_ph2", 10'd3, 2'd2, 4'hE);
    bus(8'h05, 4'b0111, 4'h0);
    expect_sig("ram_preserved", SIG_RDATA, 4'hA);
    tick();

    // Reset mid-load at word 2.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = 4'h6;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_sig("midrst_ready", SIG_READY, 4'h0);
    expect_sig("midrst_cpu", SIG_CPURST, 4'h0);
    expect_sig("midrst_done", SIG_DONE, 4'h0);
    tick();
    expect_sig("idle_ignores_valid", SIG_READY, 4'h0);
    ld_valid = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    load_prog(4'h1);
    fetch("after_rst_pc2_ph1", 10'd2, 2'd1, 4'h8);
    fetch("after_rst_pc3_ph0", 10'd3, 2'd0, 4'hA);
    bus(8'h05, 4'b0111, 4'h0);
    expect_sig("ram_reset", SIG_RDATA, 4'h0);
    tick();

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
